pico_mips4test: RTL and testbench

Top-level wrapper for the affine-transform processor used on the DE0 board. It reads two signed 8-bit coordinates (x1, y1) from the slide switches using a push-switch handshake on SW[8]. It computes x2 = 0.75·x1 + 0.5·y1 + 20 and y2 = −0.5·x1 + 0.75·y1 − 20 in fixed point, then presents x2 and y2 on the LEDs in turn. It is the topmost RTL block; board pins connect directly to it.

---
 rtl/pico_mips4test.sv | 126 ++++++++++++
 tb/tb_pico_mips4test.sv | 118 +++++++++++
 2 files changed

// File: rtl/pico_mips4test.sv
// Affine-transform processor for the DE0 board: reads x1/y1 over a SW[8] handshake, shows x2/y2.
// Optional CLKDIV_EN builds a DIV_BITS-bit clock-enable divider; otherwise every cycle is active.
module pico_mips4test #(
  parameter int unsigned       DIV_BITS = 20,
  parameter logic signed [7:0] X_OFF    = 8'sd20,
  parameter logic signed [7:0] Y_OFF    = -8'sd20
) (
  input  logic       fastclk,
  input  logic [9:0] SW,
  output logic [7:0] LED
);

  typedef enum logic [2:0] {
    StWaitXh, StWaitXl, StWaitYh, StWaitYl, StComp, StShowX, StShowYl
  } state_e;

  localparam logic signed [7:0] CoefP075 = 8'sd96;
  localparam logic signed [7:0] CoefP050 = 8'sd64;
  localparam logic signed [7:0] CoefN050 = -8'sd64;

  logic              w_rst_n;
  logic              w_en;
  logic              w_k;
  logic [1:0]        r_sync;
  state_e            r_state, w_next;
  logic [2:0]        r_cnt;
  logic signed [7:0] r_x1, r_y1, r_acc_x, r_acc_y;
  logic signed [7:0] w_coef, w_opnd, w_term;
  logic signed [15:0] w_prod;
  logic              w_ld_x1, w_ld_y1, w_acc_clr, w_acc_x, w_acc_y, w_led_x, w_led_y;
  logic              w_unused_prod;

  assign w_rst_n = SW[9];
  assign w_k     = r_sync[1];

  always_ff @(posedge fastclk or negedge w_rst_n) begin
    if (!w_rst_n) r_sync <= 2'b00;
    else          r_sync <= {r_sync[0], SW[8]};
  end

`ifdef CLKDIV_EN
  logic [DIV_BITS-1:0] r_div;
  always_ff @(posedge fastclk or negedge w_rst_n) begin
    if (!w_rst_n) r_div <= '0;
    else          r_div <= r_div + 1'b1;
  end
  assign w_en = &r_div;
`else
  logic w_unused_div;
  assign w_unused_div = (DIV_BITS != 0);
  assign w_en         = 1'b1;
`endif

  always_ff @(posedge fastclk or negedge w_rst_n) begin
    if (!w_rst_n)  r_state <= StWaitXh;
    else if (w_en) r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      StWaitXh: if (w_k)          w_next = StWaitXl;
      StWaitXl: if (!w_k)         w_next = StWaitYh;
      StWaitYh: if (w_k)          w_next = StWaitYl;
      StWaitYl: if (!w_k)         w_next = StComp;
      StComp:   if (r_cnt == 3'd4) w_next = StShowX;
      StShowX:  if (w_k)          w_next = StShowYl;
      StShowYl: if (!w_k)         w_next = StWaitXh;
      default:                    w_next = StWaitXh;
    endcase
  end

  // COMP: cnt 0..3 issue one product each, cnt 4 loads x2 onto the LEDs.
  always_comb begin
    w_ld_x1   = (r_state == StWaitXh) && w_k;
    w_ld_y1   = (r_state == StWaitYh) && w_k;
    w_acc_clr = (r_state == StWaitYl) && !w_k;
    w_acc_x   = (r_state == StComp) && (r_cnt < 3'd2);
    w_acc_y   = (r_state == StComp) && (r_cnt == 3'd2 || r_cnt == 3'd3);
    w_led_x   = (r_state == StComp) && (r_cnt == 3'd4);
    w_led_y   = (r_state == StShowX) && w_k;
  end

  always_comb begin
    w_coef = CoefP075;
    w_opnd = r_x1;
    unique case (r_cnt[1:0])
      2'd0: begin w_coef = CoefP075; w_opnd = r_x1; end
      2'd1: begin w_coef = CoefP050; w_opnd = r_y1; end
      2'd2: begin w_coef = CoefN050; w_opnd = r_x1; end
      2'd3: begin w_coef = CoefP075; w_opnd = r_y1; end
      default: ;
    endcase
  end

  // Bits [14:7] are the product shifted right by 7, truncating toward -inf.
  assign w_prod        = w_coef * w_opnd;
  assign w_term        = w_prod[14:7];
  assign w_unused_prod = w_prod[15];

  always_ff @(posedge fastclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_x1    <= '0;
      r_y1    <= '0;
      r_acc_x <= '0;
      r_acc_y <= '0;
      r_cnt   <= '0;
      LED     <= 8'h00;
    end else if (w_en) begin
      if (w_ld_x1) r_x1 <= SW[7:0];
      if (w_ld_y1) r_y1 <= SW[7:0];
      if (w_acc_clr) begin
        r_acc_x <= '0;
        r_acc_y <= '0;
      end else begin
        if (w_acc_x) r_acc_x <= r_acc_x + w_term;
        if (w_acc_y) r_acc_y <= r_acc_y + w_term;
      end
      if (r_state == StComp) r_cnt <= r_cnt + 3'd1;
      else                   r_cnt <= '0;
      if (w_led_x)      LED <= r_acc_x + X_OFF;
      else if (w_led_y) LED <= r_acc_y + Y_OFF;
    end
  end

endmodule

// File: tb/tb_pico_mips4test.sv
// Directed self-checking bench for pico_mips4test (default build, no clock divider).
module tb_pico_mips4test;

  logic       fastclk = 1'b0;
  logic [9:0] sw;
  logic [7:0] led;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 fastclk = ~fastclk;

  pico_mips4test dut (
    .fastclk(fastclk),
    .SW     (sw),
    .LED    (led)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge fastclk);
  endtask

  task automatic check(input string tag, input logic [7:0] exp);
    n_vec++;
    assert (led === exp) else begin
      n_err++;
      $error("FAIL %s: LED=%02h expected %02h", tag, led, exp);
    end
  endtask

  // x press: data is scrambled while the key is still high to prove it was latched once.
  task automatic send_x(input logic [7:0] x, input int hold);
    sw[7:0] = x;
    sw[8]   = 1'b1;
    tick(5);
    sw[7:0] = ~x;
    tick(hold - 5);
    sw[8]   = 1'b0;
    tick(5);
  endtask

  // y press, then LED must hold old for 7 edges after the drop and show x2 on the 8th.
  task automatic send_y(input logic [7:0] y, input logic [7:0] old, input logic [7:0] x2,
                        input string tag);
    sw[7:0] = y;
    sw[8]   = 1'b1;
    tick(3);
    sw[8]   = 1'b0;
    tick(7);
    check({tag, "/pre_x2"}, old);
    tick(1);
    check({tag, "/x2"}, x2);
  endtask

  task automatic show(input logic [7:0] x2, input logic [7:0] y2, input string tag);
    sw[8] = 1'b1;
    tick(2);
    check({tag, "/pre_y2"}, x2);
    tick(1);
    check({tag, "/y2"}, y2);
    sw[8] = 1'b0;
    tick(5);
  endtask

  initial begin
    sw = 10'h1A5;  // reset low, key high, arbitrary data
    tick(2);
    check("reset", 8'h00);
    sw[8] = 1'b0;
    sw[9] = 1'b1;
    tick(3);

    send_x(8'h04, 5);
    send_y(8'h08, 8'h00, 8'h1B, "basic");
    show(8'h1B, 8'hF0, "basic");

    send_x(8'h10, 5);
    send_y(8'h20, 8'hF0, 8'h30, "pair2");
    show(8'h30, 8'hFC, "pair2");

    send_x(8'hFF, 5);
    send_y(8'hFF, 8'hFC, 8'h12, "neg");
    show(8'h12, 8'hEB, "neg");

    send_x(8'h7F, 5);
    send_y(8'h7F, 8'hEB, 8'hB2, "wrap");
    show(8'hB2, 8'h0B, "wrap");

    send_x(8'h10, 50);
    send_y(8'h20, 8'h0B, 8'h30, "hold");
    show(8'h30, 8'hFC, "hold");

    // Reset two cycles into COMP, released with the key already high.
    send_x(8'h04, 5);
    sw[7:0] = 8'h7F;
    sw[8]   = 1'b1;
    tick(3);
    sw[8]   = 1'b0;
    tick(5);
    sw[9]   = 1'b0;
    sw[8]   = 1'b1;
    sw[7:0] = 8'h04;
    #1;
    check("rst_midcomp", 8'h00);
    tick(2);
    check("rst_hold", 8'h00);
    sw[9] = 1'b1;
    tick(5);
    sw[8] = 1'b0;
    tick(5);
    send_y(8'h08, 8'h00, 8'h1B, "post_rst");
    show(8'h1B, 8'hF0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
